// File: rtl/lib_uart_pkg.sv
// Constants and state encoding shared by the board UART transmitter and receiver.
// Both ends of the serial link import this package so that they agree on frame format.
package lib_uart;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } UART_TX_STATE;

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word fall-through byte queue between the CPU write path and the UART serialiser.
// An extra pointer bit distinguishes the full condition from the empty condition.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Full is judged on the registered pointers, so a same-edge pop never makes room for a push.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmitter: buffers CPU bytes in a small FIFO and serialises them LSB-first
// onto the registered, idle-high uart_tx pin at WAIT clocks per bit.
module uart_tx_ctrl
    import lib_uart::*;
#(
    parameter int WAIT  = 8,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       w_en,
    input  logic [7:0] w_data,
    output logic       w_ready,
    output logic       busy,
    output logic       uart_tx
);

    localparam int                CW        = $clog2(WAIT);
    localparam logic [CW-1:0]     WAIT_LAST = CW'(WAIT - 1);
    localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_BITS - 1);

    UART_TX_STATE         state_q, state_d;
    logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;

    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_done;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_en),
        .din   (w_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_done = (wait_cnt_q == WAIT_LAST);
    assign busy     = (state_q != IDLE) | ~fifo_empty;
    assign w_ready  = ~fifo_full;
    assign uart_tx  = tx_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        tx_d       = 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
                    state_d    = START;
                    wait_cnt_d = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d    = DATA;
                    wait_cnt_d = '0;
                    bit_idx_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    wait_cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            STOP: begin
                // A queued byte starts its start bit straight after this stop bit, with no idle gap.
                if (bit_done) begin
                    wait_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule
